// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller beside ID: register scoreboard for long-latency writers,
// RAW/WAW stall generation, N-way bypass select and a saturating stall counter.
module hazard_scoreboard #(
   parameter int NREGS   = 32,
   parameter int RAW     = $clog2(NREGS),
   parameter int NUM_FWD = 3,
   parameter int LAT_W   = 4,
   parameter int SEL_W   = $clog2(NUM_FWD + 2)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   id_valid,
   input  logic                   id_flush,
   input  logic                   id_rs1_valid,
   input  logic [RAW-1:0]         id_rs1,
   input  logic                   id_rs2_valid,
   input  logic [RAW-1:0]         id_rs2,
   input  logic                   id_rd_valid,
   input  logic [RAW-1:0]         id_rd,
   input  logic                   id_long_lat,
   input  logic [LAT_W-1:0]       id_fixed_lat,
   input  logic [NUM_FWD-1:0]     stg_rd_valid,
   input  logic [NUM_FWD*RAW-1:0] stg_rd,
   input  logic [NUM_FWD-1:0]     stg_fwd_ok,
   input  logic                   cpl_valid,
   input  logic [RAW-1:0]         cpl_rd,
   output logic                   stall,
   output logic                   issue,
   output logic [SEL_W-1:0]       fwd_rs1_sel,
   output logic [SEL_W-1:0]       fwd_rs2_sel,
   output logic [NREGS-1:0]       pending,
   output logic [31:0]            stall_cnt
);

   logic [NREGS-1:0] pending_q, pending_d;
   logic [LAT_W-1:0] cnt_q [NREGS];
   logic [LAT_W-1:0] cnt_d [NREGS];
   logic [31:0]      stall_cnt_q, stall_cnt_d;
   logic [SEL_W:0]   res1, res2;
   logic             waw, set_en;

   // Returns {hazard, select}; the youngest matching stage decides, with no fallback to older ones.
   function automatic logic [SEL_W:0] resolve(input logic rs_v, input logic [RAW-1:0] rs);
      logic             haz;
      logic             hit;
      logic [SEL_W-1:0] sel;
      haz = 1'b0;
      hit = 1'b0;
      sel = '0;
      if (rs_v && rs != '0) begin
         for (int i = 0; i < NUM_FWD; i++) begin
            if (!hit && stg_rd_valid[i] && stg_rd[i*RAW +: RAW] == rs) begin
               hit = 1'b1;
               if (stg_fwd_ok[i]) sel = SEL_W'(i + 1);
               else               haz = 1'b1;
            end
         end
         if (!hit) begin
            if (cpl_valid && cpl_rd == rs) sel = SEL_W'(NUM_FWD + 1);
            else if (pending_q[rs])        haz = 1'b1;
         end
      end
      return {haz, sel};
   endfunction

   always_comb begin
      res1  = resolve(id_rs1_valid, id_rs1);
      res2  = resolve(id_rs2_valid, id_rs2);
      waw   = id_rd_valid && (id_rd != '0) && pending_q[id_rd] && !(cpl_valid && cpl_rd == id_rd);
      stall = 1'b0;
      issue = 1'b0;
      fwd_rs1_sel = '0;
      fwd_rs2_sel = '0;
      if (!rst) begin
         stall       = id_valid && !id_flush && (res1[SEL_W] || res2[SEL_W] || waw);
         issue       = id_valid && !id_flush && !stall;
         fwd_rs1_sel = res1[SEL_W-1:0];
         fwd_rs2_sel = res2[SEL_W-1:0];
      end
      set_en = issue && id_long_lat && id_rd_valid && (id_rd != '0);
   end

   // Per-register next state: countdown, then completion clear, then issue set (set wins).
   always_comb begin
      pending_d = pending_q;
      for (int r = 0; r < NREGS; r++) begin
         cnt_d[r] = cnt_q[r];
         if (pending_q[r] && cnt_q[r] != '0) begin
            cnt_d[r] = cnt_q[r] - 1'b1;
            if (cnt_q[r] == LAT_W'(1)) pending_d[r] = 1'b0;
         end
         if (cpl_valid && cpl_rd == RAW'(r)) begin
            pending_d[r] = 1'b0;
            cnt_d[r]     = '0;
         end
         if (set_en && id_rd == RAW'(r)) begin
            pending_d[r] = 1'b1;
            cnt_d[r]     = id_fixed_lat;
         end
      end
      pending_d[0] = 1'b0;
      cnt_d[0]     = '0;
      stall_cnt_d  = stall_cnt_q;
      if (stall && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q   <= '0;
         stall_cnt_q <= '0;
         for (int r = 0; r < NREGS; r++) cnt_q[r] <= '0;
      end else begin
         pending_q   <= pending_d;
         stall_cnt_q <= stall_cnt_d;
         for (int r = 0; r < NREGS; r++) cnt_q[r] <= cnt_d[r];
      end
   end

   assign pending   = pending_q;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: load-use, fixed latency, completion bypass,
// WAW/set-wins, x0/flush and reset mid-operation.
module tb_hazard_scoreboard;
   localparam int NREGS = 32, RAW = 5, NUM_FWD = 3, LAT_W = 4, SEL_W = 3;

   logic clk = 1'b0;
   logic rst;
   logic id_valid, id_flush, id_rs1_valid, id_rs2_valid, id_rd_valid, id_long_lat;
   logic [RAW-1:0] id_rs1, id_rs2, id_rd, cpl_rd;
   logic [LAT_W-1:0] id_fixed_lat;
   logic [NUM_FWD-1:0] stg_rd_valid, stg_fwd_ok;
   logic [NUM_FWD*RAW-1:0] stg_rd;
   logic cpl_valid;
   logic stall, issue;
   logic [SEL_W-1:0] fwd_rs1_sel, fwd_rs2_sel;
   logic [NREGS-1:0] pending;
   logic [31:0] stall_cnt;

   int checks = 0;
   int errors = 0;

   hazard_scoreboard #(.NREGS(NREGS), .RAW(RAW), .NUM_FWD(NUM_FWD), .LAT_W(LAT_W), .SEL_W(SEL_W)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_flush(id_flush),
      .id_rs1_valid(id_rs1_valid), .id_rs1(id_rs1), .id_rs2_valid(id_rs2_valid), .id_rs2(id_rs2),
      .id_rd_valid(id_rd_valid), .id_rd(id_rd), .id_long_lat(id_long_lat), .id_fixed_lat(id_fixed_lat),
      .stg_rd_valid(stg_rd_valid), .stg_rd(stg_rd), .stg_fwd_ok(stg_fwd_ok),
      .cpl_valid(cpl_valid), .cpl_rd(cpl_rd), .stall(stall), .issue(issue),
      .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel), .pending(pending), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_valid = 0; id_flush = 0; id_rs1_valid = 0; id_rs1 = 0; id_rs2_valid = 0; id_rs2 = 0;
      id_rd_valid = 0; id_rd = 0; id_long_lat = 0; id_fixed_lat = 0;
      stg_rd_valid = 0; stg_rd = 0; stg_fwd_ok = 0; cpl_valid = 0; cpl_rd = 0;
   endtask

   task automatic issue_long(input logic [RAW-1:0] rd, input logic [LAT_W-1:0] lat);
      idle();
      id_valid = 1; id_rd_valid = 1; id_rd = rd; id_long_lat = 1; id_fixed_lat = lat;
      tick();
      idle();
   endtask

   task automatic test_reset();
      idle();
      rst = 1;
      id_valid = 1; id_rs1_valid = 1; id_rs1 = 5;
      stg_rd_valid = 3'b001; stg_rd = {5'd0, 5'd0, 5'd5}; stg_fwd_ok = 3'b001;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b want 0", stall); end
      checks++; if (issue !== 1'b0) begin errors++; $display("FAIL rst_issue got %b want 0", issue); end
      checks++; if (fwd_rs1_sel !== 3'd0) begin errors++; $display("FAIL rst_sel got %0d want 0", fwd_rs1_sel); end
      tick();
      rst = 0;
      idle();
      #1;
      checks++; if (pending !== 32'h0) begin errors++; $display("FAIL rst_pending got %h want 0", pending); end
      checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL rst_stall_cnt got %0d want 0", stall_cnt); end
   endtask

   task automatic test_load_use();
      idle();
      id_valid = 1; id_rs1_valid = 1; id_rs1 = 5;
      stg_rd_valid = 3'b001; stg_rd = {5'd0, 5'd0, 5'd5}; stg_fwd_ok = 3'b000;
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %b want 1", stall); end
      checks++; if (issue !== 1'b0) begin errors++; $display("FAIL lu_issue got %b want 0", issue); end
      tick();
      checks++; if (stall_cnt !== 32'd1) begin errors++; $display("FAIL lu_stall_cnt got %0d want 1", stall_cnt); end
      stg_rd_valid = 3'b010; stg_rd = {5'd0, 5'd5, 5'd0}; stg_fwd_ok = 3'b010;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_stage1_stall got %b want 0", stall); end
      checks++; if (fwd_rs1_sel !== 3'd2) begin errors++; $display("FAIL lu_stage1_sel got %0d want 2", fwd_rs1_sel); end
      checks++; if (issue !== 1'b1) begin errors++; $display("FAIL lu_issue2 got %b want 1", issue); end
      // Youngest match not ready: no fallback to an older ready stage.
      stg_rd_valid = 3'b011; stg_rd = {5'd0, 5'd5, 5'd5}; stg_fwd_ok = 3'b010;
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_nofallback got %b want 1", stall); end
      stg_rd_valid = 3'b101; stg_rd = {5'd5, 5'd0, 5'd5}; stg_fwd_ok = 3'b101;
      id_rs2_valid = 1; id_rs2 = 5;
      #1;
      checks++; if (fwd_rs1_sel !== 3'd1) begin errors++; $display("FAIL lu_youngest_sel got %0d want 1", fwd_rs1_sel); end
      checks++; if (fwd_rs2_sel !== 3'd1) begin errors++; $display("FAIL lu_rs2_sel got %0d want 1", fwd_rs2_sel); end
      idle();
      tick();
   endtask

   task automatic test_fixed_lat();
      idle();
      id_valid = 1; id_rd_valid = 1; id_rd = 7; id_long_lat = 1; id_fixed_lat = 3;
      #1;
      checks++; if (issue !== 1'b1) begin errors++; $display("FAIL fl_issue got %b want 1", issue); end
      tick();
      idle();
      id_valid = 1; id_rs1_valid = 1; id_rs1 = 7;
      #1;
      checks++; if (pending[7] !== 1'b1) begin errors++; $display("FAIL fl_pending got %b want 1", pending[7]); end
      for (int k = 1; k <= 3; k++) begin
         checks++; if (stall !== 1'b1) begin errors++; $display("FAIL fl_stall_c%0d got %b want 1", k, stall); end
         tick();
      end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fl_free got %b want 0", stall); end
      checks++; if (fwd_rs1_sel !== 3'd0) begin errors++; $display("FAIL fl_sel got %0d want 0", fwd_rs1_sel); end
      checks++; if (pending[7] !== 1'b0) begin errors++; $display("FAIL fl_cleared got %b want 0", pending[7]); end
      idle();
      tick();
   endtask

   task automatic test_cpl_bypass();
      issue_long(9, 0);
      id_valid = 1; id_rs2_valid = 1; id_rs2 = 9;
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL cb_pending_stall got %b want 1", stall); end
      cpl_valid = 1; cpl_rd = 9;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL cb_stall got %b want 0", stall); end
      checks++; if (fwd_rs2_sel !== 3'd4) begin errors++; $display("FAIL cb_sel got %0d want 4", fwd_rs2_sel); end
      tick();
      idle();
      #1;
      checks++; if (pending[9] !== 1'b0) begin errors++; $display("FAIL cb_clear got %b want 0", pending[9]); end
   endtask

   task automatic test_waw();
      issue_long(4, 0);
      id_valid = 1; id_rd_valid = 1; id_rd = 4; id_long_lat = 1;
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL waw_stall got %b want 1", stall); end
      cpl_valid = 1; cpl_rd = 4;
      #1;
      checks++; if (issue !== 1'b1) begin errors++; $display("FAIL waw_issue got %b want 1", issue); end
      tick();
      idle();
      #1;
      checks++; if (pending[4] !== 1'b1) begin errors++; $display("FAIL waw_setwins got %b want 1", pending[4]); end
      cpl_valid = 1; cpl_rd = 4;
      tick();
      idle();
      checks++; if (pending !== 32'h0) begin errors++; $display("FAIL waw_final got %h want 0", pending); end
   endtask

   task automatic test_x0_flush();
      idle();
      id_valid = 1; id_rs1_valid = 1; id_rs1 = 0;
      stg_rd_valid = 3'b001; stg_rd = 15'd0; stg_fwd_ok = 3'b000;
      id_rd_valid = 1; id_rd = 0; id_long_lat = 1;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL x0_stall got %b want 0", stall); end
      checks++; if (fwd_rs1_sel !== 3'd0) begin errors++; $display("FAIL x0_sel got %0d want 0", fwd_rs1_sel); end
      tick();
      checks++; if (pending !== 32'h0) begin errors++; $display("FAIL x0_pending got %h want 0", pending); end
      idle();
      id_valid = 1; id_flush = 1; id_rs1_valid = 1; id_rs1 = 5;
      stg_rd_valid = 3'b001; stg_rd = {5'd0, 5'd0, 5'd5}; stg_fwd_ok = 3'b000;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fl_flush_stall got %b want 0", stall); end
      checks++; if (issue !== 1'b0) begin errors++; $display("FAIL fl_flush_issue got %b want 0", issue); end
      tick();
      idle();
      // 1 load-use stall + 3 fixed-latency stalls so far
      checks++; if (stall_cnt !== 32'd4) begin errors++; $display("FAIL flush_stall_cnt got %0d want 4", stall_cnt); end
   endtask

   task automatic test_reset_mid();
      issue_long(8, 0);
      issue_long(3, 2);
      checks++; if (pending !== 32'h0000_0108) begin errors++; $display("FAIL rm_pending got %h want 00000108", pending); end
      rst = 1;
      tick();
      rst = 0;
      idle();
      id_valid = 1; id_rs1_valid = 1; id_rs1 = 3; id_rs2_valid = 1; id_rs2 = 8;
      #1;
      checks++; if (pending !== 32'h0) begin errors++; $display("FAIL rm_clear got %h want 0", pending); end
      checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL rm_stall_cnt got %0d want 0", stall_cnt); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rm_stall got %b want 0", stall); end
      tick();
      idle();
   endtask

   initial begin
      rst = 1;
      idle();
      tick();
      test_reset();
      test_load_use();
      test_fixed_lat();
      test_cpl_bypass();
      test_waw();
      test_x0_flush();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
